// File: rtl/maze_gen_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : maze_gen_ctrl_if
//  Description : Carver handshake, status and dual cell-read bundle for the
//                maze sequencing/access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface maze_gen_ctrl_if;
    logic         new_maze_i;
    logic         carver_start_o;
    logic         carver_finish_i;
    logic [255:0] maze_data_i;
    logic         maze_ready_o;
    logic         busy_o;
    logic         timeout_err_o;
    logic [7:0]   gen_count_o;
    logic         vga_req_i;
    logic [3:0]   vga_x_i;
    logic [3:0]   vga_y_i;
    logic         vga_gnt_o;
    logic         vga_cell_o;
    logic         ply_req_i;
    logic [3:0]   ply_x_i;
    logic [3:0]   ply_y_i;
    logic         ply_gnt_o;
    logic         ply_cell_o;

    modport slave (
        input  new_maze_i, carver_finish_i, maze_data_i,
        input  vga_req_i, vga_x_i, vga_y_i, ply_req_i, ply_x_i, ply_y_i,
        output carver_start_o, maze_ready_o, busy_o, timeout_err_o, gen_count_o,
        output vga_gnt_o, vga_cell_o, ply_gnt_o, ply_cell_o
    );

    modport master (
        output new_maze_i, carver_finish_i, maze_data_i,
        output vga_req_i, vga_x_i, vga_y_i, ply_req_i, ply_x_i, ply_y_i,
        input  carver_start_o, maze_ready_o, busy_o, timeout_err_o, gen_count_o,
        input  vga_gnt_o, vga_cell_o, ply_gnt_o, ply_cell_o
    );
endinterface
`default_nettype wire

// File: rtl/maze_gen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : maze_gen_ctrl
//  Description : Runs one carve per request with timeout, snapshots the maze
//                and serves round-robin cell reads to VGA and player logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_gen_ctrl #(
    parameter int GRID_W         = 16,
    parameter int GRID_H         = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic           clk,
    input  logic           rst_n,
    maze_gen_ctrl_if.slave bus
);

    localparam int          c_CELLS   = GRID_W * GRID_H;
    localparam logic [23:0] c_TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_READY   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [23:0]          cnt_q, cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 new_maze_q;
    logic [c_CELLS-1:0]   snap_q;
    logic [7:0]           gen_cnt_q;
    logic                 carver_start_q, maze_ready_q, busy_q;
    logic                 rr_q;
    logic                 vga_gnt_q, ply_gnt_q, vga_cell_q, ply_cell_q;

    logic                 w_edge;
    logic                 w_vga_elig, w_ply_elig, w_vga_win, w_ply_win;
    logic [7:0]           w_vga_idx, w_ply_idx;

    assign w_edge = bus.new_maze_i & ~new_maze_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE, S_READY: begin
                if (w_edge) begin
                    state_d       = S_START;
                    cnt_d         = 24'd0;
                    timeout_err_d = 1'b0;
                end
            end
            S_START, S_RUN: begin
                // Timeout wins over a finish transition in the same cycle.
                if (cnt_q == c_TO_LAST) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                    if (state_q == S_START && !bus.carver_finish_i)
                        state_d = S_RUN;
                    else if (state_q == S_RUN && bus.carver_finish_i)
                        state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_READY;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 24'd0;
            timeout_err_q  <= 1'b0;
            new_maze_q     <= 1'b0;
            carver_start_q <= 1'b0;
            maze_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timeout_err_q  <= timeout_err_d;
            new_maze_q     <= bus.new_maze_i;
            carver_start_q <= (state_d == S_START);
            maze_ready_q   <= (state_d == S_READY);
            busy_q         <= (state_d == S_START) || (state_d == S_RUN) ||
                              (state_d == S_CAPTURE);
        end
    end

    // A requester granted last cycle is still holding req while it reacts,
    // so it is masked for one cycle to avoid a duplicate grant.
    assign w_vga_elig = maze_ready_q & bus.vga_req_i & ~vga_gnt_q;
    assign w_ply_elig = maze_ready_q & bus.ply_req_i & ~ply_gnt_q;
    assign w_vga_win  = w_vga_elig & (~w_ply_elig | ~rr_q);
    assign w_ply_win  = w_ply_elig & ~w_vga_win;
    assign w_vga_idx  = {bus.vga_y_i, bus.vga_x_i};
    assign w_ply_idx  = {bus.ply_y_i, bus.ply_x_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q     <= '0;
            gen_cnt_q  <= 8'd0;
            rr_q       <= 1'b0;
            vga_gnt_q  <= 1'b0;
            ply_gnt_q  <= 1'b0;
            vga_cell_q <= 1'b0;
            ply_cell_q <= 1'b0;
        end else begin
            if (state_q == S_CAPTURE) begin
                snap_q    <= bus.maze_data_i;
                gen_cnt_q <= gen_cnt_q + 8'd1;
            end
            vga_gnt_q  <= w_vga_win;
            ply_gnt_q  <= w_ply_win;
            vga_cell_q <= w_vga_win & snap_q[w_vga_idx];
            ply_cell_q <= w_ply_win & snap_q[w_ply_idx];
            if (w_vga_win)
                rr_q <= 1'b1;
            else if (w_ply_win)
                rr_q <= 1'b0;
        end
    end

    assign bus.carver_start_o = carver_start_q;
    assign bus.maze_ready_o   = maze_ready_q;
    assign bus.busy_o         = busy_q;
    assign bus.timeout_err_o  = timeout_err_q;
    assign bus.gen_count_o    = gen_cnt_q;
    assign bus.vga_gnt_o      = vga_gnt_q;
    assign bus.vga_cell_o     = vga_cell_q;
    assign bus.ply_gnt_o      = ply_gnt_q;
    assign bus.ply_cell_o     = ply_cell_q;

endmodule
`default_nettype wire
